// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: NOP payload, occupancy type,
// stage FSM encoding and per-stage payload field layout.
package pipe_pkg;

  typedef logic [1:0] occ_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Wide enough for any stage; slice down to WIDTH at the use site.
  localparam int NOP_MAX_W = 512;
  localparam logic [NOP_MAX_W-1:0] NOP_PAYLOAD = '0;

  // IF/ID payload: {pc, ir}
  localparam int IFID_IR_OFF  = 0;
  localparam int IFID_IR_W    = 32;
  localparam int IFID_PC_OFF  = IFID_IR_OFF + IFID_IR_W;
  localparam int IFID_PC_W    = 32;
  localparam int IFID_WIDTH   = IFID_PC_OFF + IFID_PC_W;

  // ID/EX payload: {ctrl, imm, rs2_val, rs1_val, pc}
  localparam int IDEX_PC_OFF   = 0;
  localparam int IDEX_PC_W     = 32;
  localparam int IDEX_RS1_OFF  = IDEX_PC_OFF + IDEX_PC_W;
  localparam int IDEX_RS1_W    = 32;
  localparam int IDEX_RS2_OFF  = IDEX_RS1_OFF + IDEX_RS1_W;
  localparam int IDEX_RS2_W    = 32;
  localparam int IDEX_IMM_OFF  = IDEX_RS2_OFF + IDEX_RS2_W;
  localparam int IDEX_IMM_W    = 32;
  localparam int IDEX_CTRL_OFF = IDEX_IMM_OFF + IDEX_IMM_W;
  localparam int IDEX_CTRL_W   = 16;
  localparam int IDEX_WIDTH    = IDEX_CTRL_OFF + IDEX_CTRL_W;

  // EX/MEM payload: {ctrl, store_val, alu_res}
  localparam int EXMEM_ALU_OFF  = 0;
  localparam int EXMEM_ALU_W    = 32;
  localparam int EXMEM_ST_OFF   = EXMEM_ALU_OFF + EXMEM_ALU_W;
  localparam int EXMEM_ST_W     = 32;
  localparam int EXMEM_CTRL_OFF = EXMEM_ST_OFF + EXMEM_ST_W;
  localparam int EXMEM_CTRL_W   = 8;
  localparam int EXMEM_WIDTH    = EXMEM_CTRL_OFF + EXMEM_CTRL_W;

  // MEM/WB payload: {ctrl, wb_val}
  localparam int MEMWB_VAL_OFF  = 0;
  localparam int MEMWB_VAL_W    = 32;
  localparam int MEMWB_CTRL_OFF = MEMWB_VAL_OFF + MEMWB_VAL_W;
  localparam int MEMWB_CTRL_W   = 6;
  localparam int MEMWB_WIDTH    = MEMWB_CTRL_OFF + MEMWB_CTRL_W;

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+payload register. Priority: rst > clr > load. Reset always zeroes
// the payload; clr zeroes it only when CLEAR_DATA is set.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      if (CLEAR_DATA) begin
        data_d = NOP_PAYLOAD[WIDTH-1:0];
      end
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= NOP_PAYLOAD[WIDTH-1:0];
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic stage register with valid/ready handshake, optional skid entry,
// flush and bubble insertion.
//
//   state    | meaning
//   ST_EMPTY | M and S invalid
//   ST_ONE   | M valid, S invalid
//   ST_FULL  | M and S valid, in_ready low (SKID=1 only)
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SKID       = 1'b1,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bubble,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  stage_state_e state_d, state_q;

  logic             m_valid, s_valid;
  logic [WIDTH-1:0] m_data,  s_data;
  logic             m_load, m_clr, m_from_s;
  logic             s_load, s_clr;
  logic [WIDTH-1:0] new_data, m_load_data;
  logic             accept, pop;

  assign new_data    = in_bubble ? NOP_PAYLOAD[WIDTH-1:0] : in_data;
  assign m_load_data = m_from_s ? s_data : new_data;
  assign accept      = in_valid & in_ready;
  assign pop         = m_valid & out_ready;

  if (SKID) begin : g_ready_reg
    // Depends only on a flop, so stalls stop here instead of rippling upstream.
    assign in_ready = !s_valid;
  end else begin : g_ready_comb
    assign in_ready = !m_valid | out_ready;
  end

  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    m_clr    = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
      m_clr   = 1'b1;
      s_clr   = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            m_load  = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            m_load = 1'b1;
          end else if (accept) begin
            // Only reachable with SKID=1; with SKID=0 in_ready needs a pop here.
            s_load  = SKID;
            state_d = SKID ? ST_FULL : ST_ONE;
          end else if (pop) begin
            m_clr   = 1'b1;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_clr    = 1'b1;
            state_d  = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          m_clr   = 1'b1;
          s_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_entry_reg #(.WIDTH(WIDTH), .CLEAR_DATA(CLEAR_DATA)) u_m (
    .clk       (clk),
    .rst       (rst),
    .clr       (m_clr),
    .load      (m_load),
    .load_data (m_load_data),
    .valid     (m_valid),
    .data      (m_data)
  );

  pipe_entry_reg #(.WIDTH(WIDTH), .CLEAR_DATA(CLEAR_DATA)) u_s (
    .clk       (clk),
    .rst       (rst),
    .clr       (s_clr),
    .load      (s_load),
    .load_data (new_data),
    .valid     (s_valid),
    .data      (s_data)
  );

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a SKID=1 instance (a_*) and a
// SKID=0 instance (b_*) sharing clock and reset.
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_in_bubble, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic        b_flush, b_in_valid, b_in_ready, b_in_bubble, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;

  int errors = 0;
  int checks = 0;

  pipe_stage_elastic #(.WIDTH(32), .SKID(1'b1), .CLEAR_DATA(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bubble(a_in_bubble), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .occupancy(a_occ)
  );

  pipe_stage_elastic #(.WIDTH(32), .SKID(1'b0), .CLEAR_DATA(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bubble(b_in_bubble), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .occupancy(b_occ)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_chk(input string tag, input logic v, input logic [31:0] d,
                       input logic [1:0] occ, input logic rdy);
    check({tag, ".out_valid"}, 64'(a_out_valid), 64'(v));
    check({tag, ".out_data"},  64'(a_out_data),  64'(d));
    check({tag, ".occupancy"}, 64'(a_occ),       64'(occ));
    check({tag, ".in_ready"},  64'(a_in_ready),  64'(rdy));
  endtask

  task automatic b_chk(input string tag, input logic v, input logic [31:0] d,
                       input logic [1:0] occ);
    check({tag, ".out_valid"}, 64'(b_out_valid), 64'(v));
    check({tag, ".out_data"},  64'(b_out_data),  64'(d));
    check({tag, ".occupancy"}, 64'(b_occ),       64'(occ));
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b1; a_in_bubble = 1'b0; a_in_data = 32'hDEADBEEF; a_out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b1; b_in_bubble = 1'b0; b_in_data = 32'hDEADBEEF; b_out_ready = 1'b1;

    // Reset held two cycles with a live offer.
    step(); step();
    a_chk("rst", 1'b0, 32'h0, 2'd0, 1'b1);
    b_chk("rst_b", 1'b0, 32'h0, 2'd0);
    rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    step();
    a_chk("post_rst", 1'b0, 32'h0, 2'd0, 1'b1);

    // Streaming at full throughput.
    a_out_ready = 1'b1; a_in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_in_data = 32'(i);
      step();
      a_chk($sformatf("stream%0d", i), 1'b1, 32'(i), 2'd1, 1'b1);
    end
    a_in_valid = 1'b0;
    step();
    a_chk("stream_drain", 1'b0, 32'h0, 2'd0, 1'b1);

    // Backpressure into the skid entry; 0xC must wait for in_ready.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
    step();
    a_chk("bp_a", 1'b1, 32'hA, 2'd1, 1'b1);
    a_in_data = 32'hB;
    step();
    a_chk("bp_full", 1'b1, 32'hA, 2'd2, 1'b0);
    a_in_data = 32'hC;
    for (int i = 0; i < 3; i++) begin
      step();
      a_chk($sformatf("bp_hold%0d", i), 1'b1, 32'hA, 2'd2, 1'b0);
    end
    a_out_ready = 1'b1;
    step();
    a_chk("bp_pop_a", 1'b1, 32'hB, 2'd1, 1'b1);
    step();
    a_chk("bp_take_c", 1'b1, 32'hC, 2'd1, 1'b1);
    a_in_valid = 1'b0;
    step();
    a_chk("bp_drain", 1'b0, 32'h0, 2'd0, 1'b1);

    // Bubble stores a zero payload but is still a valid entry.
    a_in_valid = 1'b1; a_in_bubble = 1'b1; a_in_data = 32'h12345678;
    step();
    a_chk("bubble", 1'b1, 32'h0, 2'd1, 1'b1);
    a_in_bubble = 1'b0; a_in_data = 32'h55;
    step();
    a_chk("after_bubble", 1'b1, 32'h55, 2'd1, 1'b1);
    a_in_valid = 1'b0;
    step();

    // Flush from FULL, with a transfer offered in the flush cycle.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
    step();
    a_in_data = 32'hB;
    step();
    a_chk("fl_full", 1'b1, 32'hA, 2'd2, 1'b0);
    a_flush = 1'b1; a_in_data = 32'hC;
    step();
    a_chk("flush", 1'b0, 32'h0, 2'd0, 1'b1);
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    step();
    a_chk("flush_no_c", 1'b0, 32'h0, 2'd0, 1'b1);

    // SKID=0: combinational in_ready and replace-on-pop.
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h7;
    #1;
    check("b_rdy_empty", 64'(b_in_ready), 64'd1);
    step();
    b_chk("b_load7", 1'b1, 32'h7, 2'd1);
    b_in_data = 32'h8;
    #1;
    check("b_rdy_stall", 64'(b_in_ready), 64'd0);
    step();
    b_chk("b_stall", 1'b1, 32'h7, 2'd1);
    b_out_ready = 1'b1;
    #1;
    check("b_rdy_release", 64'(b_in_ready), 64'd1);
    step();
    b_chk("b_replace8", 1'b1, 32'h8, 2'd1);
    b_in_valid = 1'b0;
    step();
    b_chk("b_drain", 1'b0, 32'h0, 2'd0);

    // Reset mid-transfer discards a full stage.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h21;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; a_in_valid = 1'b0;
    a_chk("mid_rst", 1'b0, 32'h0, 2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
